// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 multiply / divide engine for the EX stage.
// Multiply is shift-add, divide is restoring; both run WIDTH iterations on
// operand magnitudes and apply sign correction on the final iteration.
// result_o carries {hi, lo}: the full product, or {remainder, quotient}.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               op_i,
    input  logic               signed_i,
    input  logic               annul_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               busy_o,
    output logic               div_by_zero_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               op_q;        // 0 = multiply, 1 = divide
    logic               neg_res_q;   // negate product / quotient at the end
    logic               neg_rem_q;   // negate remainder (dividend was negative)
    logic [WIDTH-1:0]   opnd_q;      // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0] acc_q;       // mul: {hi, multiplier}; div: {rem, quo}
    logic [2*WIDTH-1:0] result_q;
    logic               dbz_q;

    logic               sign1;
    logic               sign2;
    logic [WIDTH-1:0]   mag1;
    logic [WIDTH-1:0]   mag2;
    logic               accept;
    logic               div_zero;
    logic               last_iter;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_sh;
    logic               trial_neg;
    logic [WIDTH-1:0]   trial_rem;
    logic [WIDTH-1:0]   quo_mag;
    logic [WIDTH-1:0]   rem_mag;
    logic [2*WIDTH-1:0] acc_step;
    logic [2*WIDTH-1:0] acc_final;

    assign sign1     = signed_i & opdata1_i[WIDTH-1];
    assign sign2     = signed_i & opdata2_i[WIDTH-1];
    assign mag1      = sign1 ? -opdata1_i : opdata1_i;
    assign mag2      = sign2 ? -opdata2_i : opdata2_i;
    assign accept    = start_i & ~annul_i;
    assign div_zero  = op_i & (opdata2_i == '0);
    assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

    // One radix-2 iteration of the current operation, plus its sign-corrected form.
    always_comb begin
        // NOTE: every signal gets a default first, so no path can leave one
        // unassigned and infer a latch.
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
        rem_sh    = acc_q[2*WIDTH-1:WIDTH-1];
        trial_neg = (rem_sh < {1'b0, opnd_q});
        // The true difference is below the divisor, so WIDTH bits hold it exactly.
        trial_rem = rem_sh[WIDTH-1:0] - opnd_q;
        acc_step  = acc_q;
        quo_mag   = '0;
        rem_mag   = '0;
        acc_final = '0;

        if (acc_q[0]) begin
            mul_sum = mul_sum + {1'b0, opnd_q};
        end

        if (!op_q) begin
            // Add-then-shift-right: carry enters hi, multiplier bit leaves lo.
            acc_step  = {mul_sum, acc_q[WIDTH-1:1]};
            acc_final = neg_res_q ? -acc_step : acc_step;
        end else begin
            // Shift left, keep the trial difference only if it stayed non-negative.
            if (trial_neg) begin
                acc_step = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end else begin
                acc_step = {trial_rem, acc_q[WIDTH-2:0], 1'b1};
            end
            quo_mag   = acc_step[WIDTH-1:0];
            rem_mag   = acc_step[2*WIDTH-1:WIDTH];
            // minint / -1 falls out naturally: magnitude 2^(WIDTH-1), no negation.
            acc_final = {(neg_rem_q ? -rem_mag : rem_mag),
                         (neg_res_q ? -quo_mag : quo_mag)};
        end
    end

    // Next-state logic for the IDLE / BUSY / DONE handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = div_zero ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (annul_i) begin
                    state_d = IDLE;
                end else if (last_iter) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!start_i || annul_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block ordering.
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand capture, iteration datapath and result holding.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            op_q      <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            opnd_q    <= '0;
            acc_q     <= '0;
            result_q  <= '0;
            dbz_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_q      <= op_i;
                        neg_res_q <= sign1 ^ sign2;
                        neg_rem_q <= sign1;
                        cnt_q     <= '0;
                        result_q  <= '0;
                        dbz_q     <= div_zero;
                        if (op_i) begin
                            acc_q  <= {{WIDTH{1'b0}}, mag1};
                            opnd_q <= mag2;
                        end else begin
                            acc_q  <= {{WIDTH{1'b0}}, mag2};
                            opnd_q <= mag1;
                        end
                    end
                end
                BUSY: begin
                    if (!annul_i) begin
                        acc_q <= acc_step;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (last_iter) begin
                            result_q <= acc_final;
                        end
                    end
                end
                DONE: begin
                    if (!start_i || annul_i) begin
                        result_q <= '0;
                        dbz_q    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign result_o      = result_q;
    assign ready_o       = (state_q == DONE);
    assign busy_o        = (state_q == BUSY);
    assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and randomized checks of muldiv_unit (WIDTH=32)
// against a transaction-level reference model using plain 64-bit arithmetic.
module tb_muldiv_unit;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic           op = 1'b0;
    logic           sgn = 1'b0;
    logic           annul = 1'b0;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic [2*W-1:0] result;
    logic           ready;
    logic           busy;
    logic           dbz;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start),
        .op_i          (op),
        .signed_i      (sgn),
        .annul_i       (annul),
        .opdata1_i     (a),
        .opdata2_i     (b),
        .result_o      (result),
        .ready_o       (ready),
        .busy_o        (busy),
        .div_by_zero_o (dbz)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference result computed with ordinary integer arithmetic.
    function automatic logic [63:0] golden(input logic o, input logic s,
                                           input logic [31:0] x, input logic [31:0] y);
        longint      sx, sy, sq, sr;
        logic [63:0] ux, uy, uq, ur;
        ux = {32'b0, x};
        uy = {32'b0, y};
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        if (!o) begin
            if (s) return sx * sy;
            return ux * uy;
        end
        if (y == 0) return '0;
        if (s) begin
            sq = sx / sy;
            sr = sx % sy;
            return {sr[31:0], sq[31:0]};
        end
        uq = ux / uy;
        ur = ux % uy;
        return {ur[31:0], uq[31:0]};
    endfunction

    // Transaction model: tracks when a result is due and what it must be.
    typedef enum {M_IDLE, M_RUN, M_HOLD} mphase_t;
    mphase_t     m_phase = M_IDLE;
    int          m_left = 0;
    logic [63:0] m_pending = '0;
    logic [63:0] exp_result = '0;
    logic        exp_ready = 1'b0;
    logic        exp_busy = 1'b0;
    logic        exp_dbz = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_phase    <= M_IDLE;
            exp_result <= '0;
            exp_ready  <= 1'b0;
            exp_busy   <= 1'b0;
            exp_dbz    <= 1'b0;
        end else begin
            case (m_phase)
                M_IDLE: if (start && !annul) begin
                    if (op && b == 0) begin
                        m_phase    <= M_HOLD;
                        exp_ready  <= 1'b1;
                        exp_dbz    <= 1'b1;
                        exp_result <= '0;
                    end else begin
                        m_phase   <= M_RUN;
                        m_left    <= W;
                        exp_busy  <= 1'b1;
                        m_pending <= golden(op, sgn, a, b);
                    end
                end
                M_RUN: begin
                    if (annul) begin
                        m_phase  <= M_IDLE;
                        exp_busy <= 1'b0;
                    end else if (m_left == 1) begin
                        m_phase    <= M_HOLD;
                        exp_busy   <= 1'b0;
                        exp_ready  <= 1'b1;
                        exp_result <= m_pending;
                    end else begin
                        m_left <= m_left - 1;
                    end
                end
                M_HOLD: if (!start || annul) begin
                    m_phase    <= M_IDLE;
                    exp_ready  <= 1'b0;
                    exp_dbz    <= 1'b0;
                    exp_result <= '0;
                end
                default: m_phase <= M_IDLE;
            endcase
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc busy_o", busy, exp_busy);
            check("cyc ready_o", ready, exp_ready);
            check("cyc div_by_zero_o", dbz, exp_dbz);
            check("cyc result_o", result, exp_result);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Counts cycles until ready_o, bounded; also counts cycles with busy_o high.
    task automatic wait_ready(input string name, output int n, output int nb);
        n  = 0;
        nb = 0;
        do begin
            tick();
            n++;
            if (busy) nb++;
        end while (!ready && n < 200);
        if (!ready) check({name, " timeout waiting for ready_o"}, ready, 1'b1);
    endtask

    task automatic run_op(input string name, input logic o, input logic s,
                          input logic [31:0] x, input logic [31:0] y,
                          input int exp_lat, input logic [63:0] exp_res, input logic exp_z);
        int n, nb;
        op = o; sgn = s; a = x; b = y; start = 1'b1;
        wait_ready(name, n, nb);
        check({name, " latency"}, n, exp_lat);
        check({name, " busy cycles"}, nb, exp_lat - 1);
        check({name, " result"}, result, exp_res);
        check({name, " dbz"}, dbz, exp_z);
        tick();
        check({name, " ready held"}, ready, 1'b1);
        check({name, " result held"}, result, exp_res);
        check({name, " dbz held"}, dbz, exp_z);
        start = 1'b0;
        tick();
        check({name, " ready dropped"}, ready, 1'b0);
        check({name, " result cleared"}, result, 64'h0);
        check({name, " dbz cleared"}, dbz, 1'b0);
        check({name, " back to idle"}, busy, 1'b0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return $urandom_range(0, 15);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n, nb, k, abort_at;
        bit  aborted, seen;

        // Pin the reference model with hand-computed values.
        check("model -3*5", golden(1'b0, 1'b1, 32'hFFFF_FFFD, 32'd5), 64'hFFFF_FFFF_FFFF_FFF1);
        check("model -7/2", golden(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2), 64'hFFFF_FFFF_FFFF_FFFD);
        check("model 100/7", golden(1'b1, 1'b0, 32'd100, 32'd7), 64'h0000_0002_0000_000E);
        check("model minint/-1", golden(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF),
              64'h0000_0000_8000_0000);

        tick();
        tick();
        rst = 1'b0;
        chk_en = 1'b1;
        check("reset busy_o", busy, 1'b0);
        check("reset ready_o", ready, 1'b0);
        check("reset result_o", result, 64'h0);
        check("reset div_by_zero_o", dbz, 1'b0);

        run_op("umul max", 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33,
               64'hFFFF_FFFE_0000_0001, 1'b0);
        run_op("smul -3*5", 1'b0, 1'b1, 32'hFFFF_FFFD, 32'd5, 33,
               64'hFFFF_FFFF_FFFF_FFF1, 1'b0);
        run_op("sdiv -7/2", 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 33,
               64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
        run_op("udiv 100/7", 1'b1, 1'b0, 32'd100, 32'd7, 33,
               64'h0000_0002_0000_000E, 1'b0);
        run_op("div by zero", 1'b1, 1'b0, 32'd5, 32'd0, 1, 64'h0, 1'b1);
        run_op("sdiv overflow", 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33,
               64'h0000_0000_8000_0000, 1'b0);

        // Start together with annul must not launch anything.
        op = 1'b0; sgn = 1'b0; a = 32'd3; b = 32'd4; start = 1'b1; annul = 1'b1;
        tick();
        tick();
        check("start+annul stays idle busy", busy, 1'b0);
        check("start+annul stays idle ready", ready, 1'b0);
        start = 1'b0; annul = 1'b0;
        tick();

        // Abort a multiply in cycle 10, restart in cycle 11, done in cycle 44.
        op = 1'b0; sgn = 1'b0; a = 32'h1234_5678; b = 32'h9ABC_DEF0; start = 1'b1;
        seen = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (ready) seen = 1'b1;
        end
        check("abort busy in cycle 10", busy, 1'b1);
        annul = 1'b1;
        tick();
        if (ready) seen = 1'b1;
        check("abort idle in cycle 11", busy, 1'b0);
        check("abort ready never asserted", seen, 1'b0);
        annul = 1'b0; a = 32'h0001_0000; b = 32'h0001_0000;
        wait_ready("restart mul", n, nb);
        check("restart ready cycle", 11 + n, 44);
        check("restart result", result, 64'h0000_0001_0000_0000);
        start = 1'b0;
        tick();

        // Reset pulse in the middle of a divide.
        op = 1'b1; sgn = 1'b1; a = 32'hFFFF_FF9C; b = 32'd7; start = 1'b1;
        repeat (6) tick();
        check("pre-reset busy", busy, 1'b1);
        rst = 1'b1; start = 1'b0;
        tick();
        check("mid-op reset busy_o", busy, 1'b0);
        check("mid-op reset ready_o", ready, 1'b0);
        check("mid-op reset result_o", result, 64'h0);
        check("mid-op reset div_by_zero_o", dbz, 1'b0);
        rst = 1'b0;
        tick();

        // Randomized operations; outputs are checked every cycle against the model.
        for (int t = 0; t < 60; t++) begin
            op = 1'($urandom_range(0, 1));
            sgn = 1'($urandom_range(0, 1));
            a = pick();
            b = pick();
            annul = 1'b0;
            start = 1'b1;
            abort_at = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, W)) : 0;
            aborted = 1'b0;
            k = 0;
            do begin
                tick();
                k++;
                if (!ready) begin
                    a = $urandom;
                    b = $urandom;
                end
                if (abort_at == k && busy) begin
                    annul = 1'b1;
                    start = 1'b0;
                    aborted = 1'b1;
                end
            end while (!ready && !aborted && k < 200);
            if (!aborted) begin
                check("random op completes", ready, 1'b1);
                repeat ($urandom_range(0, 2)) tick();
                if ($urandom_range(0, 3) == 0) begin
                    annul = 1'b1;
                end else begin
                    start = 1'b0;
                end
            end
            tick();
            annul = 1'b0;
            start = 1'b0;
            tick();
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
